sum_bcd_converter: RTL and testbench

// - Downstream stage of the N-bit ripple adder: converts its (N+1)-bit unsigned sum into packed BCD digits for the 7-segment display path.
// - Sequential double-dabble (shift-and-add-3): one bit is processed per clock, with a start/busy/done handshake.
// - The BCD result is registered and holds steady between conversions, so display logic reads it directly.
//

---
 rtl/sum_bcd_converter_pkg.sv | 25 ++
 rtl/sum_bcd_converter_bcd_add3.sv | 12 +
 rtl/sum_bcd_converter.sv | 109 ++++++++++
 tb/tb_sum_bcd_converter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_bcd_converter_pkg.sv
// Shared types and constants for the adder-sum to BCD converter.
package sum_bcd_converter_pkg;

    // Converter FSM states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Double-dabble correction: digits of 5 or more get 3 added before the shift.
    localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
    localparam logic [3:0] BCD_CORR_ADD    = 4'd3;

    // 10**e for the elaboration-time capacity check (shift/add only, no multiply by variable).
    function automatic longint unsigned pow10(input int unsigned e);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < e; i++) begin
            r = (r << 3) + (r << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_bcd_converter_bcd_add3.sv
// Single BCD digit correction cell: adds 3 to a digit of 5 or more.
module bcd_add3
    import sum_bcd_converter_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    // Digit is at most 9 here, so the 4-bit add never carries out.
    assign dout_c = (din >= BCD_CORR_THRESH) ? (din + BCD_CORR_ADD) : din;

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter from the (N+1)-bit adder sum to packed BCD.
module sum_bcd_converter
    import sum_bcd_converter_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N:0]            sum,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SW = N + 1;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned RW = BW + SW;
    localparam int unsigned CW = $clog2(N + 2);

    // Reject digit counts that cannot hold the largest possible sum.
    if (pow10(DIGITS) <= ((64'd1 << SW) - 64'd1)) begin : g_digits_too_small
        $error("sum_bcd_converter: DIGITS too small for an (N+1)-bit sum");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [RW-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]   bcd_q,   bcd_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [RW-1:0]   corr_c;
    logic [RW-1:0]   shifted_c;

    // Binary part passes through uncorrected.
    assign corr_c[SW-1:0] = shreg_q[SW-1:0];

    // One correction cell per BCD digit field of the shift register.
    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_add3 u_add3 (
            .din    (shreg_q[SW + 4*i +: 4]),
            .dout_c (corr_c[SW + 4*i +: 4])
        );
    end

    // Corrected register shifted left by one bit position.
    assign shifted_c = corr_c << 1;

    // Next-state, counter, shift register and output register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = {BW'(0), sum};
                    cnt_d   = CW'(SW);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = shifted_c;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = shifted_c[RW-1 -: BW];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter at default and N=8/DIGITS=3 sizes.
module tb_sum_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start4;
    logic [4:0]  sum4;
    logic        busy4, done4;
    logic [7:0]  bcd4;

    logic        start8;
    logic [8:0]  sum8;
    logic        busy8, done8;
    logic [11:0] bcd8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_bcd_converter #(.N(4), .DIGITS(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .sum   (sum4),
        .busy  (busy4),
        .done  (done4),
        .bcd   (bcd4)
    );

    sum_bcd_converter #(.N(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .sum   (sum8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8)
    );

    // Reference: decimal digits by repeated division, packed 4 bits each.
    function automatic logic [11:0] ref_bcd(input int unsigned v);
        logic [11:0] r;
        r = '0;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on the default-size instance; optionally changes sum after capture.
    task automatic conv4(input logic [4:0] v, input bit chg, input logic [4:0] v2, input string tag);
        int          lat;
        logic [11:0] r;
        logic [7:0]  exp;
        logic [7:0]  prev;
        r    = ref_bcd(int'(v));
        exp  = r[7:0];
        prev = bcd4;
        lat  = 0;
        start4 = 1'b1;
        sum4   = v;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                start4 = 1'b0;
                chk({tag, " busy_after_start"}, 32'(busy4), 32'd1);
                if (chg) sum4 = v2;
            end
            if (i == 3) chk({tag, " bcd_hold"}, 32'(bcd4), 32'(prev));
            if (done4) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd6);
        chk({tag, " bcd"}, 32'(bcd4), 32'(exp));
        chk({tag, " busy_in_done"}, 32'(busy4), 32'd1);
        tick();
        chk({tag, " done_one_cycle"}, 32'(done4), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy4), 32'd0);
        chk({tag, " bcd_holds"}, 32'(bcd4), 32'(exp));
    endtask

    // One conversion on the N=8 instance.
    task automatic conv8(input logic [8:0] v, input string tag);
        int          lat;
        logic [11:0] exp;
        exp = ref_bcd(int'(v));
        lat = 0;
        start8 = 1'b1;
        sum8   = v;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd10);
        chk({tag, " bcd"}, 32'(bcd8), 32'(exp));
        tick();
    endtask

    initial begin
        logic [4:0] rv;
        bit         prev_done;
        bit         saw_done;

        rst_n  = 1'b0;
        start4 = 1'b0;
        sum4   = '0;
        start8 = 1'b0;
        sum8   = '0;
        #12;
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset bcd", 32'(bcd4), 32'd0);
        chk("reset bcd8", 32'(bcd8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Full-scale and digit-boundary values.
        conv4(5'd31, 1'b0, 5'd0, "sum31");
        conv4(5'd0,  1'b0, 5'd0, "sum0");
        conv4(5'd10, 1'b0, 5'd0, "sum10");
        conv4(5'd9,  1'b0, 5'd0, "sum9");

        // start held high: accepted only from IDLE, one conversion per 7 cycles.
        prev_done = 1'b0;
        start4 = 1'b1;
        sum4   = 5'd17;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("b2b done", 32'(done4), 32'((i % 7) == 6));
            chk("b2b busy", 32'(busy4), 32'((i % 7) != 0));
            chk("b2b no_double_done", 32'(done4 && prev_done), 32'd0);
            if (done4) chk("b2b bcd", 32'(bcd4), 32'h17);
            prev_done = done4;
        end
        start4 = 1'b0;
        tick();
        tick();

        // Reset in the middle of SHIFT aborts the conversion.
        start4 = 1'b1;
        sum4   = 5'd23;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        chk("abort busy_before", 32'(busy4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        chk("abort bcd", 32'(bcd4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done4) saw_done = 1'b1;
        end
        chk("abort no_done", 32'(saw_done), 32'd0);
        conv4(5'd23, 1'b0, 5'd0, "after_abort");

        // Sum changes after capture are ignored.
        conv4(5'd23, 1'b1, 5'd4, "sum_change");

        // Random values against the reference.
        for (int k = 0; k < 30; k++) begin
            rv = 5'($urandom_range(0, 31));
            conv4(rv, 1'b0, 5'd0, "random");
        end

        // Wider configuration: full scale then an exhaustive sweep.
        conv8(9'd511, "n8_511");
        for (int v = 0; v < 512; v++) begin
            conv8(9'(v), "n8_sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
